// File: rtl/iter_comparator.sv
// ---------------------------------------------------------------------------
// iter_comparator
//   Multi-cycle magnitude comparator. An operand pair is accepted over a
//   valid/ready handshake. It is then compared MSB-first, DIGIT bits per
//   cycle. Signed less-than, unsigned less-than and equality are returned
//   over a second valid/ready handshake.
//
// Parameters
//   WIDTH  operand width; must be a positive multiple of DIGIT
//   DIGIT  bits compared per cycle (N = WIDTH/DIGIT compare cycles)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair a/b presented
//   in_ready   block can accept (high exactly in IDLE)
//   a, b       operands, two's complement or unsigned
//   out_valid  result valid (high exactly in DONE)
//   out_ready  consumer takes result
//   lt         $signed(a) < $signed(b)
//   ltu        a < b, unsigned
//   eq         a == b
//
// Build option
//   CMP_EARLY_EXIT_EN  when defined, RUN leaves for DONE on the edge that
//                      finds the first differing digit. Results are
//                      identical either way; only the latency changes.
//
// States
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready = 1
//   RUN   | comparing one digit per cycle, MSB digit first
//   DONE  | result presented, out_valid = 1, waiting for out_ready
// ---------------------------------------------------------------------------
module iter_comparator #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             ltu,
  output logic             eq
);

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if ((DIGIT < 1) || (WIDTH < 1) ||
      ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_bad_params
    $error("iter_comparator: WIDTH must be a positive multiple of DIGIT (DIGIT >= 1)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [KW-1:0]    k_q, k_d;
  logic             decided_q, decided_d;
  logic             ltu_r_q, ltu_r_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;
  logic             eq_q, eq_d;

  // Operands are shifted left each RUN cycle, so the digit under compare
  // always sits in the top DIGIT bits; no variable part-select is needed.
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             hit;
  logic             finish;

  assign a_dig = a_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    k_d       = k_q;
    decided_d = decided_q;
    ltu_r_d   = ltu_r_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    eq_d      = eq_q;
    hit       = 1'b0;
    finish    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          sa_d      = a[WIDTH-1];
          sb_d      = b[WIDTH-1];
          k_d       = '0;
          decided_d = 1'b0;
          ltu_r_d   = 1'b0;
          state_d   = RUN;
        end
      end

      RUN: begin
        // Only the first differing digit decides the unsigned order.
        hit = !decided_q && (a_dig != b_dig);
        if (hit) begin
          decided_d = 1'b1;
          ltu_r_d   = (a_dig < b_dig);
        end
        a_d    = a_q << DIGIT;
        b_d    = b_q << DIGIT;
        k_d    = k_q + 1'b1;
        finish = (k_q == K_LAST);
`ifdef CMP_EARLY_EXIT_EN
        finish = finish || hit;
`else
        finish = finish;
`endif
        if (finish) begin
          // Results load from the post-compare flags so that a decision
          // made on this very edge is included.
          eq_d    = !decided_d;
          ltu_d   = ltu_r_d;
          lt_d    = (sa_q != sb_q) ? sa_q : ltu_r_d;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      k_q       <= '0;
      decided_q <= 1'b0;
      ltu_r_q   <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      k_q       <= k_d;
      decided_q <= decided_d;
      ltu_r_q   <= ltu_r_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
      eq_q      <= eq_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign eq        = eq_q;

endmodule

// File: tb/tb_iter_comparator.sv
module tb_iter_comparator;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  // 12-bit / 3-bit instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [11:0] a, b;
  logic        lt, ltu, eq;

  // 6-bit / 2-bit instance for the exhaustive sweep
  logic        in_valid6, in_ready6, out_valid6, out_ready6;
  logic [5:0]  a6, b6;
  logic        lt6, ltu6, eq6;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iter_comparator #(.WIDTH(12), .DIGIT(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .lt(lt), .ltu(ltu), .eq(eq)
  );

  iter_comparator #(.WIDTH(6), .DIGIT(2)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6),
    .a(a6), .b(b6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .lt(lt6), .ltu(ltu6), .eq(eq6)
  );

  typedef struct {
    string       name;
    logic [11:0] va;
    logic [11:0] vb;
    logic        e_lt;
    logic        e_ltu;
    logic        e_eq;
    int          lat_full;
    int          lat_early;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Assumes the DUT is in IDLE; returns results and cycles from accept edge
  // to the first sample with out_valid (99 on timeout).
  task automatic run_txn12(input logic [11:0] ta, input logic [11:0] tb_v,
                           output logic r_lt, output logic r_ltu, output logic r_eq,
                           output int lat);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_after_accept", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = 99;
    r_lt  = lt;
    r_ltu = ltu;
    r_eq  = eq;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r_lt, r_ltu, r_eq;
    int   lat;
    int   exp_lat;

    //          name        a        b       lt    ltu   eq   full early
    vecs[0] = '{"neg_vs_pos", 12'h800, 12'h7FF, 1'b1, 1'b0, 1'b0, 4, 1};
    vecs[1] = '{"equal_abc",  12'hABC, 12'hABC, 1'b0, 1'b0, 1'b1, 4, 4};
    vecs[2] = '{"lsd_diff",   12'h005, 12'h006, 1'b1, 1'b1, 1'b0, 4, 4};
    vecs[3] = '{"m1_vs_0",    12'hFFF, 12'h000, 1'b1, 1'b0, 1'b0, 4, 1};
    vecs[4] = '{"digit2",     12'h123, 12'h12B, 1'b1, 1'b1, 1'b0, 4, 3};
    vecs[5] = '{"pos_gt",     12'h400, 12'h200, 1'b0, 1'b0, 1'b0, 4, 1};
    vecs[6] = '{"neg_neg_lt", 12'hFFE, 12'hFFF, 1'b1, 1'b1, 1'b0, 4, 4};
    vecs[7] = '{"neg_neg_gt", 12'h840, 12'h800, 1'b0, 1'b0, 1'b0, 4, 2};
    vecs[8] = '{"zeros",      12'h000, 12'h000, 1'b0, 1'b0, 1'b1, 4, 4};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid6 = 1'b0; a6 = '0; b6 = '0; out_ready6 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_results",   {lt, ltu, eq}, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    // ---- table-driven vectors ----
    for (int i = 0; i < 9; i++) begin
      run_txn12(vecs[i].va, vecs[i].vb, r_lt, r_ltu, r_eq, lat);
      exp_lat = EARLY ? vecs[i].lat_early : vecs[i].lat_full;
      check({vecs[i].name, "_lt"},  r_lt,  vecs[i].e_lt);
      check({vecs[i].name, "_ltu"}, r_ltu, vecs[i].e_ltu);
      check({vecs[i].name, "_eq"},  r_eq,  vecs[i].e_eq);
      check({vecs[i].name, "_latency"}, lat, exp_lat);
      @(posedge clk); #1;
      check({vecs[i].name, "_back_idle"}, {out_valid, in_ready}, 2'b01);
    end

    // ---- backpressure ----
    out_ready = 1'b0;
    run_txn12(12'h7FF, 12'h800, r_lt, r_ltu, r_eq, lat);
    check("bp_latency", lat, EARLY ? 1 : 4);
    check("bp_results", {r_lt, r_ltu, r_eq}, 3'b010);
    for (int c = 0; c < 5; c++) begin
      in_valid = ~in_valid;
      a = 12'h000;
      b = 12'h000;
      @(posedge clk); #1;
      check("bp_hold_valid",   {out_valid, in_ready}, 2'b10);
      check("bp_hold_results", {lt, ltu, eq}, 3'b010);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle",    {out_valid, in_ready}, 2'b01);
    check("bp_release_results", {lt, ltu, eq}, 3'b010);
    @(posedge clk); #1;
    check("bp_no_capture", {out_valid, in_ready}, 2'b01);

    // ---- reset mid-transaction ----
    a = 12'h001;
    b = 12'h002;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_run_busy", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready",  in_ready, 1'b1);
    check("async_rst_results",   {lt, ltu, eq}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_idle", {out_valid, in_ready}, 2'b01);
    run_txn12(12'hFFF, 12'h000, r_lt, r_ltu, r_eq, lat);
    check("after_rst_results", {r_lt, r_ltu, r_eq}, 3'b100);
    check("after_rst_latency", lat, EARLY ? 1 : 4);
    @(posedge clk); #1;

    // ---- exhaustive 6-bit / 2-bit sweep ----
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 64; bi++) begin
        logic [5:0] va, vb;
        logic       m_lt, m_ltu, m_eq;
        int         m_lat, slat;
        bit         found;
        va = 6'(ai);
        vb = 6'(bi);
        m_lt  = ($signed(va) < $signed(vb));
        m_ltu = (va < vb);
        m_eq  = (va === vb);
        m_lat = 3;
        found = 1'b0;
        if (EARLY) begin
          for (int d = 0; d < 3; d++) begin
            if (!found && (va[5-2*d -: 2] != vb[5-2*d -: 2])) begin
              m_lat = d + 1;
              found = 1'b1;
            end
          end
        end
        a6 = va;
        b6 = vb;
        in_valid6 = 1'b1;
        @(posedge clk); #1;
        in_valid6 = 1'b0;
        slat = 0;
        while (!out_valid6 && slat < 20) begin
          @(posedge clk); #1;
          slat++;
        end
        if (!out_valid6) slat = 99;
        check($sformatf("sweep_a%0h_b%0h", va, vb),
              {21'd0, lt6, ltu6, eq6, slat[7:0]},
              {21'd0, m_lt, m_ltu, m_eq, m_lat[7:0]});
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iter_comparator.md
# iter_comparator

Parametrised, multi-cycle magnitude comparator generalising the single-cycle 6-bit lt/ltu/eq comparator. It accepts a WIDTH-bit operand pair over a valid/ready handshake and compares it MSB-first, DIGIT bits per cycle. It returns signed less-than, unsigned less-than and equality over a second valid/ready handshake. It sits in the lab datapath wherever wide compares must meet timing without a full-width carry chain.

## Interface
- WIDTH, 12, operand width in bits; must be a positive multiple of DIGIT.
- DIGIT, 3, bits compared per cycle; N = WIDTH/DIGIT compare cycles.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a/b presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, two's complement or unsigned.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- lt  output  1  $signed(a) < $signed(b).
- ltu  output  1  a < b, unsigned.
- eq  output  1  a == b.

## Operation
- States: IDLE, RUN, DONE.
- Reset is asynchronous: state goes to IDLE, and lt, ltu, eq and out_valid go to 0.
- in_ready is 1 exactly in IDLE, so it is 1 out of reset. out_valid is 1 exactly in DONE.
- IDLE:
  - On in_valid && in_ready, register a and b, capture sign bits sa = a[WIDTH-1] and sb = b[WIDTH-1].
  - Clear the digit index to 0 and the running flags (decided = 0, ltu_r = 0), then go to RUN.
- RUN:
  - Each cycle, compare digit k of the registered operands, with k = 0 as the most significant DIGIT bits.
  - If not yet decided and the digits differ, set decided = 1 and ltu_r = (a_digit < b_digit).
  - Increment k. After the compare of digit N-1, go to DONE.
- DONE entry, result registers load:
  - eq = !decided.
  - ltu = ltu_r.
  - lt = (sa != sb) ? sa : ltu_r.
- DONE:
  - lt, ltu and eq are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. lt, ltu and eq keep their values until the next DONE entry.
- Backpressure: in_valid is ignored outside IDLE. Operand inputs need only be stable on the accepting edge.
- No bypass: a result handoff and a new acceptance never occur on the same edge, giving a one-cycle bubble minimum between transactions.
- Reset mid-RUN or mid-DONE aborts the transaction; the result is discarded.
- Illegal parameters (WIDTH % DIGIT != 0, or DIGIT < 1) stop elaboration with $error.

## Timing
- Accept edge = edge 0.
- Full latency: RUN processes digits on edges 1..N. out_valid is 1 in the cycle after edge N.
- Early-exit latency (macro defined): if the first differing digit is j, out_valid is 1 in the cycle after edge j+1. Equal operands always take N.
- Minimum transaction period is N+2 cycles: accept, N compare cycles, DONE with out_ready = 1, return to IDLE.
- All outputs are registered or decoded only from state; no combinational path from inputs to outputs.

## Configuration
- CMP_EARLY_EXIT_EN.
  - Defined: RUN goes to DONE on the same edge that sets decided, skipping the remaining digits.
  - Not defined: latency is fixed at N for every operand pair.
- Result values are identical in both builds.

## Test plan
All scenarios use WIDTH=12, DIGIT=3 (N=4) unless stated otherwise.
- a=0x800, b=0x7FF, out_ready=1 -> lt=1, ltu=0, eq=0. out_valid after edge 4, or after edge 1 with CMP_EARLY_EXIT_EN.
- a=b=0xABC -> eq=1, lt=0, ltu=0. out_valid after edge 4 in both builds.
- a=0x005, b=0x006 -> lt=1, ltu=1, eq=0. The difference is in digit 3, so out_valid comes after edge 4 in both builds.
- Backpressure: a=0x7FF, b=0x800; hold out_ready=0 for 5 cycles while toggling in_valid.
  - Expect lt=0, ltu=1, eq=0, held stable; in_ready stays 0 and no new capture occurs.
  - Raising out_ready gives IDLE next cycle.
- Reset mid-transaction: assert rst 2 cycles after accepting a=0x001, b=0x002.
  - Outputs go to 0 and out_valid to 0 immediately (asynchronous); in_ready is 1 after release.
  - The next transaction (a=0xFFF, b=0x000) gives lt=1, ltu=0.
- WIDTH=6, DIGIT=2: exhaustive sweep of all 4096 (a,b) pairs, back-to-back with out_ready=1.
  - Each result must match the $signed/unsigned/=== model in both builds.
  - Error count must be 0.
